pong_match_fsm: RTL and testbench



---
 rtl/pong_pkg.sv | 43 ++++
 rtl/btn_edge_sync.sv | 34 +++
 rtl/pong_match_fsm.sv | 159 +++++++++++++++
 tb/tb_pong_match_fsm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: match-level codes shared by the pong objects.
// Holds state enum, game_state and player codes, display size.
package pong_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_SERVE = 2'b10;
  localparam logic [1:0] GS_OVER  = 2'b11;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_P1   = 2'b01;
  localparam logic [1:0] WHO_P2   = 2'b10;
  localparam logic [1:0] WHO_BOTH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_PAUSED,
    ST_OVER
  } match_state_t;

  // PAUSED shares the SERVE code; the ball only needs "frozen"
  function automatic logic [1:0] state_code(
    input match_state_t s
  );
    logic [1:0] c;
    c = GS_IDLE;
    unique case (s)
      ST_IDLE:   c = GS_IDLE;
      ST_SERVE:  c = GS_SERVE;
      ST_PLAY:   c = GS_PLAY;
      ST_PAUSED: c = GS_SERVE;
      ST_OVER:   c = GS_OVER;
      default:   c = GS_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: 2-flop synchroniser and rising-edge pulse
// for one asynchronous push button.
module btn_edge_sync
  import pong_pkg::*;
(
  input  logic clk_1ms,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // metastability chain plus last-seen level, cleared on reset
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // one pulse per press, however long it is held
  always_comb begin
    pulse = sync2 & ~prev;
  end

endmodule

// File: rtl/pong_match_fsm.sv
// pong_match_fsm: IDLE/SERVE/PLAY/GAME_OVER match controller.
// Define PONG_PAUSE_EN to add the PAUSED state on pause_btn.
module pong_match_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int TIMER_W        = 10
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [3:0] p1_score,
  input  logic [3:0] p2_score,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic [1:0] last_scorer,
  output logic       serve_busy
);

  localparam logic [3:0] WIN =
    4'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] LOAD =
    TIMER_W'(SERVE_DELAY_MS - 1);

  match_state_t state;
  match_state_t state_d;

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_d;

  logic [1:0] winner_d;
  logic [1:0] last_d;

  logic [3:0] p1_prev;
  logic [3:0] p2_prev;

  logic p1_chg;
  logic p2_chg;
  logic p1_win;
  logic p2_win;

  logic start_pls;
  logic pause_pls;

  btn_edge_sync u_start (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn     (start_btn),
    .pulse   (start_pls)
  );

`ifdef PONG_PAUSE_EN
  btn_edge_sync u_pause (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn     (pause_btn),
    .pulse   (pause_pls)
  );
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign pause_pls    = 1'b0;
`endif

  // score-change and win detect against last cycle's scores
  always_comb begin
    p1_chg = (p1_score != p1_prev);
    p2_chg = (p2_score != p2_prev);
    p1_win = (p1_score >= WIN);
    p2_win = (p2_score >= WIN);
  end

  // previous scores track every cycle so stale changes never linger
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      p1_prev <= 4'd0;
      p2_prev <= 4'd0;
    end else begin
      p1_prev <= p1_score;
      p2_prev <= p2_score;
    end
  end

  // match state, serve timer and result registers
  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      winner      <= WHO_NONE;
      last_scorer <= WHO_NONE;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      winner      <= winner_d;
      last_scorer <= last_d;
    end
  end

  // next-state: a point wins or reloads the serve delay
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    winner_d = winner;
    last_d   = last_scorer;
    unique case (state)
      ST_IDLE: begin
        if (start_pls) begin
          state_d = ST_SERVE;
          timer_d = LOAD;
        end
      end
      ST_SERVE: begin
        if (timer == '0) begin
          state_d = ST_PLAY;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      ST_PLAY: begin
        if (p1_chg || p2_chg) begin
          last_d = {p2_chg, p1_chg};
          if (p1_win || p2_win) begin
            state_d  = ST_OVER;
            winner_d = {p2_win, p1_win};
          end else begin
            state_d = ST_SERVE;
            timer_d = LOAD;
          end
        end else if (pause_pls) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
`ifdef PONG_PAUSE_EN
        if (pause_pls) begin
          state_d = ST_PLAY;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // outputs decode directly from the registered state
  always_comb begin
    game_state = state_code(state);
    serve_busy = (state == ST_SERVE);
  end

endmodule

// File: tb/tb_pong_match_fsm.sv
// tb_pong_match_fsm: directed test of the match controller
// with SERVE_DELAY_MS=5, WIN_SCORE=3.
module tb_pong_match_fsm;

  logic       clk_1ms;
  logic       reset;
  logic       start_btn;
  logic       pause_btn;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] game_state;
  logic [1:0] winner;
  logic [1:0] last_scorer;
  logic       serve_busy;

  int n_chk;
  int n_err;

  pong_match_fsm #(
    .WIN_SCORE      (3),
    .SERVE_DELAY_MS (5),
    .TIMER_W        (4)
  ) dut (
    .clk_1ms     (clk_1ms),
    .reset       (reset),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .game_state  (game_state),
    .winner      (winner),
    .last_scorer (last_scorer),
    .serve_busy  (serve_busy)
  );

  initial clk_1ms = 1'b0;
  always #5 clk_1ms = ~clk_1ms;

  task automatic chk(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1ms);
      #1;
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick(3);
    start_btn = 1'b0;
  endtask

  task automatic wait_serve(input string tag);
    tick(4);
    chk({tag, "_hold"}, {2'b0, game_state}, 4'h2);
    tick(1);
    chk({tag, "_play"}, {2'b0, game_state}, 4'h1);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    p1_score  = 4'd0;
    p2_score  = 4'd0;
    tick(2);
    chk("rst_gs", {2'b0, game_state}, 4'h0);
    chk("rst_win", {2'b0, winner}, 4'h0);
    chk("rst_last", {2'b0, last_scorer}, 4'h0);
    chk("rst_busy", {3'b0, serve_busy}, 4'h0);
    reset = 1'b1;
    tick(1);

    start_btn = 1'b1;
    tick(1);
    chk("st_e1", {2'b0, game_state}, 4'h0);
    tick(1);
    chk("st_e2", {2'b0, game_state}, 4'h0);
    tick(1);
    chk("st_e3", {2'b0, game_state}, 4'h2);
    chk("st_busy", {3'b0, serve_busy}, 4'h1);
    tick(1);
    start_btn = 1'b0;
    tick(3);
    chk("st_hold", {2'b0, game_state}, 4'h2);
    tick(1);
    chk("st_play", {2'b0, game_state}, 4'h1);
    chk("st_busy0", {3'b0, serve_busy}, 4'h0);
    tick(3);
    chk("st_once", {2'b0, game_state}, 4'h1);

    p1_score = 4'd1;
    tick(1);
    chk("p1_gs", {2'b0, game_state}, 4'h2);
    chk("p1_last", {2'b0, last_scorer}, 4'h1);
    wait_serve("p1");

    p2_score = 4'd1;
    tick(1);
    chk("p2_last", {2'b0, last_scorer}, 4'h2);
    wait_serve("p2");

    p1_score = 4'd2;
    p2_score = 4'd2;
    tick(1);
    chk("both_gs", {2'b0, game_state}, 4'h2);
    chk("both_last", {2'b0, last_scorer}, 4'h3);
    wait_serve("both");

    p1_score = 4'd3;
    p2_score = 4'd3;
    tick(1);
    chk("tie_gs", {2'b0, game_state}, 4'h3);
    chk("tie_win", {2'b0, winner}, 4'h3);

    reset    = 1'b0;
    p1_score = 4'd2;
    p2_score = 4'd2;
    tick(1);
    chk("rst2_gs", {2'b0, game_state}, 4'h0);
    chk("rst2_win", {2'b0, winner}, 4'h0);
    reset = 1'b1;
    tick(2);
    press_start();
    chk("g2_serve", {2'b0, game_state}, 4'h2);
    wait_serve("g2");
    p2_score = 4'd3;
    tick(1);
    chk("p2w_gs", {2'b0, game_state}, 4'h3);
    chk("p2w_win", {2'b0, winner}, 4'h2);
    start_btn = 1'b1;
    tick(4);
    start_btn = 1'b0;
    tick(2);
    p1_score = 4'd0;
    tick(2);
    chk("over_gs", {2'b0, game_state}, 4'h3);
    chk("over_win", {2'b0, winner}, 4'h2);

    reset    = 1'b0;
    p1_score = 4'd0;
    p2_score = 4'd0;
    tick(1);
    reset = 1'b1;
    tick(2);
    press_start();
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("mid_gs", {2'b0, game_state}, 4'h0);
    chk("mid_busy", {3'b0, serve_busy}, 4'h0);
    chk("mid_win", {2'b0, winner}, 4'h0);
    reset    = 1'b1;
    p1_score = 4'd1;
    tick(2);
    p2_score = 4'd5;
    tick(2);
    chk("idle_gs", {2'b0, game_state}, 4'h0);

`ifdef PONG_PAUSE_EN
    press_start();
    wait_serve("g3");
    pause_btn = 1'b1;
    tick(3);
    pause_btn = 1'b0;
    chk("pz_gs", {2'b0, game_state}, 4'h2);
    chk("pz_busy", {3'b0, serve_busy}, 4'h0);
    p1_score = 4'd2;
    tick(2);
    chk("pz_hold", {2'b0, game_state}, 4'h2);
    chk("pz_last", {2'b0, last_scorer}, 4'h0);
    pause_btn = 1'b1;
    tick(3);
    pause_btn = 1'b0;
    chk("pz_exit", {2'b0, game_state}, 4'h1);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
